// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache: FSM state encoding,
// a constant log2 helper and the address/word width constants.
package cache_pkg;

    localparam int unsigned ADDR_BITS = 32;
    localparam int unsigned WORD_BITS = 32;

    typedef enum logic [1:0] {
        LOOKUP = 2'd0,
        WB     = 2'd1,
        FETCH  = 2'd2,
        FILL   = 2'd3
    } state_e;

    // Ceiling log2, usable in parameter elaboration.
    function automatic int unsigned LOG2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Byte-offset width of a line holding block_size 32-bit words.
    function automatic int unsigned block_pos(input int unsigned block_size);
        return LOG2(block_size) + 2;
    endfunction

    // Set-index width for a cache of 2^cache_size bytes.
    function automatic int unsigned set_bits(input int unsigned cache_size,
                                             input int unsigned block_size,
                                             input int unsigned ways);
        return cache_size - block_pos(block_size) - LOG2(ways);
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One way of the cache: per-set valid/dirty status, tag and line storage.
// Read combinationally at set_i; written on clk by a line fill or a word store.
module cache_way_array import cache_pkg::*; #(
    parameter int unsigned SET_BITS   = 5,
    parameter int unsigned TAG_WIDTH  = 23,
    parameter int unsigned BLOCK_SIZE = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SET_BITS-1:0]             set_i,
    input  logic [LOG2(BLOCK_SIZE)-1:0]     word_i,
    input  logic [WORD_BITS-1:0]            wdata_i,
    input  logic                            store_en_i,
    input  logic                            fill_en_i,
    input  logic [TAG_WIDTH-1:0]            fill_tag_i,
    input  logic [BLOCK_SIZE*WORD_BITS-1:0] fill_line_i,
    output logic                            valid_o,
    output logic                            dirty_o,
    output logic [TAG_WIDTH-1:0]            tag_o,
    output logic [BLOCK_SIZE*WORD_BITS-1:0] line_o
);

    localparam int unsigned SETS   = 1 << SET_BITS;
    localparam int unsigned LINE_W = BLOCK_SIZE * WORD_BITS;

    logic [SETS-1:0]      valid_q;
    logic [SETS-1:0]      dirty_q;
    logic [TAG_WIDTH-1:0] tag_q  [SETS];
    logic [LINE_W-1:0]    line_q [SETS];

    assign valid_o = valid_q[set_i];
    assign dirty_o = dirty_q[set_i];
    assign tag_o   = tag_q[set_i];
    assign line_o  = line_q[set_i];

    // Status bits: cleared on reset, set clean-valid on fill, dirtied on store.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_en_i) begin
            valid_q[set_i] <= 1'b1;
            dirty_q[set_i] <= 1'b0;
        end else if (store_en_i) begin
            dirty_q[set_i] <= 1'b1;
        end
    end

    // Tag and data storage, no reset needed since valid qualifies them.
    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_q[set_i]  <= fill_tag_i;
            line_q[set_i] <= fill_line_i;
        end else if (store_en_i) begin
            line_q[set_i][{word_i, 5'b00000} +: WORD_BITS] <= wdata_i;
        end
    end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative write-back/write-allocate cache with per-set
// round-robin replacement. Define CACHE_STATS_EN to add the Hit_Cnt,
// Miss_Cnt and WB_Cnt event counters.
module assoc_cache import cache_pkg::*; #(
    parameter  int unsigned CACHE_SIZE = 12,
    parameter  int unsigned BLOCK_SIZE = 8,
    parameter  int unsigned WAYS       = 2,
    localparam int unsigned BLOCK_POS  = block_pos(BLOCK_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            Req_CPU,
    input  logic                            Wr_CPU,
    input  logic [31:0]                     A_CPU,
    input  logic [31:0]                     DI_CPU,
    output logic [31:0]                     DO_CPU,
    output logic                            Rdy_CPU,
    output logic                            Req_Low,
    output logic                            Wr_Low,
    output logic [31-BLOCK_POS:0]           A_Low,
    output logic [BLOCK_SIZE*32-1:0]        DO_Low,
    input  logic [BLOCK_SIZE*32-1:0]        DI_Low,
    input  logic                            Rdy_Low
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                     Hit_Cnt,
    output logic [31:0]                     Miss_Cnt,
    output logic [31:0]                     WB_Cnt
`endif
);

    localparam int unsigned WAY_LOG   = LOG2(WAYS);
    localparam int unsigned WAY_W     = (WAY_LOG == 0) ? 1 : WAY_LOG;
    localparam int unsigned SET_BITS  = set_bits(CACHE_SIZE, BLOCK_SIZE, WAYS);
    localparam int unsigned TAG_WIDTH = ADDR_BITS - BLOCK_POS - SET_BITS;
    localparam int unsigned SETS      = 1 << SET_BITS;
    localparam int unsigned WORD_W    = BLOCK_POS - 2;
    localparam int unsigned LINE_W    = BLOCK_SIZE * WORD_BITS;

    logic [TAG_WIDTH-1:0] req_tag;
    logic [SET_BITS-1:0]  req_set;
    logic [WORD_W-1:0]    req_word;
    logic                 unused_addr;

    assign req_tag     = A_CPU[31 -: TAG_WIDTH];
    assign req_set     = A_CPU[BLOCK_POS +: SET_BITS];
    assign req_word    = A_CPU[2 +: WORD_W];
    assign unused_addr = ^A_CPU[1:0];

    logic [WAYS-1:0]      way_valid;
    logic [WAYS-1:0]      way_dirty;
    logic [TAG_WIDTH-1:0] way_tag  [WAYS];
    logic [LINE_W-1:0]    way_line [WAYS];
    logic [WAYS-1:0]      store_en;
    logic [WAYS-1:0]      fill_en;

    state_e            state_q, state_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic              vfree_q, vfree_d;
    logic [LINE_W-1:0] fill_q, fill_d;

    logic              hit;
    logic [WAY_W-1:0]  hit_way;
    logic              free_found;
    logic [WAY_W-1:0]  free_way;
    logic [WAY_W-1:0]  rr_cur;
    logic [WAY_W-1:0]  victim_sel;
    logic              rr_inc;
    logic [LINE_W-1:0] hit_line;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        cache_way_array #(
            .SET_BITS   (SET_BITS),
            .TAG_WIDTH  (TAG_WIDTH),
            .BLOCK_SIZE (BLOCK_SIZE)
        ) u_way (
            .clk         (clk),
            .rst         (rst),
            .set_i       (req_set),
            .word_i      (req_word),
            .wdata_i     (DI_CPU),
            .store_en_i  (store_en[g]),
            .fill_en_i   (fill_en[g]),
            .fill_tag_i  (req_tag),
            .fill_line_i (fill_q),
            .valid_o     (way_valid[g]),
            .dirty_o     (way_dirty[g]),
            .tag_o       (way_tag[g]),
            .line_o      (way_line[g])
        );
    end

    if (WAYS > 1) begin : g_rr
        logic [SETS-1:0][WAY_W-1:0] rr_q;
        assign rr_cur = rr_q[req_set];

        // Round-robin pointer advances only when a valid line was displaced.
        always_ff @(posedge clk) begin
            if (rst) begin
                rr_q <= '0;
            end else if (rr_inc) begin
                rr_q[req_set] <= rr_q[req_set] + 1'b1;
            end
        end
    end else begin : g_no_rr
        assign rr_cur = '0;
    end

    // Tag match and victim choice: lowest invalid way, else round-robin.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (way_valid[WAY_W'(w)] && (way_tag[WAY_W'(w)] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!way_valid[WAY_W'(w)] && !free_found) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
        victim_sel = free_found ? free_way : rr_cur;
        hit_line   = way_line[hit_way];
        DO_CPU     = hit_line[{req_word, 5'b00000} +: WORD_BITS];
    end

    // FSM state, latched victim and refill capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= LOOKUP;
            victim_q <= '0;
            vfree_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            vfree_q  <= vfree_d;
        end
        fill_q <= fill_d;
    end

    // Next-state, handshake outputs and array write enables.
    always_comb begin
        state_d  = state_q;
        victim_d = victim_q;
        vfree_d  = vfree_q;
        fill_d   = fill_q;
        Rdy_CPU  = 1'b0;
        Req_Low  = 1'b0;
        Wr_Low   = 1'b0;
        A_Low    = A_CPU[31:BLOCK_POS];
        DO_Low   = way_line[victim_q];
        store_en = '0;
        fill_en  = '0;
        rr_inc   = 1'b0;
        case (state_q)
            LOOKUP: begin
                if (Req_CPU) begin
                    if (hit) begin
                        Rdy_CPU = 1'b1;
                        if (Wr_CPU) begin
                            store_en[hit_way] = 1'b1;
                        end
                    end else begin
                        victim_d = victim_sel;
                        vfree_d  = free_found;
                        state_d  = (way_valid[victim_sel] && way_dirty[victim_sel]) ? WB : FETCH;
                    end
                end
            end
            WB: begin
                Req_Low = 1'b1;
                Wr_Low  = 1'b1;
                A_Low   = {way_tag[victim_q], req_set};
                if (Rdy_Low) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                Req_Low = 1'b1;
                if (Rdy_Low) begin
                    fill_d  = DI_Low;
                    state_d = FILL;
                end
            end
            FILL: begin
                fill_en[victim_q] = 1'b1;
                rr_inc            = !vfree_q;
                state_d           = LOOKUP;
            end
            default: state_d = LOOKUP;
        endcase
        // A reset during FILL must not install the line or move the pointer.
        if (rst) begin
            store_en = '0;
            fill_en  = '0;
            rr_inc   = 1'b0;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;
    logic        hit_evt, miss_evt, wb_evt;

    assign hit_evt  = (state_q == LOOKUP) && Req_CPU && hit;
    assign miss_evt = (state_q == LOOKUP) && Req_CPU && !hit;
    assign wb_evt   = (state_q == WB) && Rdy_Low;
    assign Hit_Cnt  = hit_cnt_q;
    assign Miss_Cnt = miss_cnt_q;
    assign WB_Cnt   = wb_cnt_q;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_q + {31'd0, hit_evt};
            miss_cnt_q <= miss_cnt_q + {31'd0, miss_evt};
            wb_cnt_q   <= wb_cnt_q + {31'd0, wb_evt};
        end
    end
`endif

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (CACHE_SIZE=10, BLOCK_SIZE=4, WAYS=2).
module tb_assoc_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic         Req_CPU, Wr_CPU;
    logic [31:0]  A_CPU, DI_CPU, DO_CPU;
    logic         Rdy_CPU, Req_Low, Wr_Low, Rdy_Low;
    logic [27:0]  A_Low;
    logic [127:0] DO_Low, DI_Low;
`ifdef CACHE_STATS_EN
    logic [31:0]  Hit_Cnt, Miss_Cnt, WB_Cnt;
`endif

    int total = 0;
    int bad   = 0;
    int exp_hit = 0, exp_miss = 0, exp_wb = 0;

    always #5 clk = ~clk;

    assoc_cache #(
        .CACHE_SIZE (10),
        .BLOCK_SIZE (4),
        .WAYS       (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .Req_CPU  (Req_CPU),
        .Wr_CPU   (Wr_CPU),
        .A_CPU    (A_CPU),
        .DI_CPU   (DI_CPU),
        .DO_CPU   (DO_CPU),
        .Rdy_CPU  (Rdy_CPU),
        .Req_Low  (Req_Low),
        .Wr_Low   (Wr_Low),
        .A_Low    (A_Low),
        .DO_Low   (DO_Low),
        .DI_Low   (DI_Low),
        .Rdy_Low  (Rdy_Low)
`ifdef CACHE_STATS_EN
        ,
        .Hit_Cnt  (Hit_Cnt),
        .Miss_Cnt (Miss_Cnt),
        .WB_Cnt   (WB_Cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [127:0] mkline(input logic [31:0] base);
        return {base + 32'd3, base + 32'd2, base + 32'd1, base};
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] line, input logic [31:0] addr);
        logic [1:0] w;
        w = addr[3:2];
        return line[{w, 5'b00000} +: 32];
    endfunction

    task automatic chk_stats(input string tag);
`ifdef CACHE_STATS_EN
        chk({tag, "_hits"}, Hit_Cnt, exp_hit);
        chk({tag, "_misses"}, Miss_Cnt, exp_miss);
        chk({tag, "_wbs"}, WB_Cnt, exp_wb);
`else
        chk({tag, "_idle_rdy"}, Rdy_CPU, (Req_CPU === 1'b1) ? Rdy_CPU : 1'b0);
`endif
    endtask

    task automatic load_hit(input logic [31:0] addr, input logic [31:0] exp_d);
        Req_CPU = 1'b1; Wr_CPU = 1'b0; A_CPU = addr;
        #1;
        chk("ld_hit_rdy", Rdy_CPU, 1'b1);
        chk("ld_hit_data", DO_CPU, exp_d);
        chk("ld_hit_noreq", Req_Low, 1'b0);
        exp_hit++;
        tick;
    endtask

    task automatic store_hit(input logic [31:0] addr, input logic [31:0] data);
        Req_CPU = 1'b1; Wr_CPU = 1'b1; A_CPU = addr; DI_CPU = data;
        #1;
        chk("st_hit_rdy", Rdy_CPU, 1'b1);
        chk("st_hit_noreq", Req_Low, 1'b0);
        exp_hit++;
        tick;
        Wr_CPU = 1'b0;
    endtask

    // Load miss: optional writeback, fetch, fill, then the hit cycle.
    task automatic load_miss(input logic [31:0] addr, input logic dirty,
                             input logic [27:0] wb_alow, input logic [127:0] wb_line,
                             input logic [127:0] line);
        Req_CPU = 1'b1; Wr_CPU = 1'b0; A_CPU = addr;
        #1;
        chk("miss_rdy", Rdy_CPU, 1'b0);
        chk("miss_lookup_noreq", Req_Low, 1'b0);
        exp_miss++;
        tick;
        if (dirty) begin
            chk("wb_req", Req_Low, 1'b1);
            chk("wb_wr", Wr_Low, 1'b1);
            chk("wb_alow", A_Low, wb_alow);
            chk("wb_line", DO_Low, wb_line);
            tick;
            chk("wb_hold_alow", A_Low, wb_alow);
            chk("wb_hold_line", DO_Low, wb_line);
            Rdy_Low = 1'b1;
            tick;
            Rdy_Low = 1'b0;
            exp_wb++;
        end
        chk("fetch_req", Req_Low, 1'b1);
        chk("fetch_wr", Wr_Low, 1'b0);
        chk("fetch_alow", A_Low, addr[31:4]);
        chk("fetch_rdy", Rdy_CPU, 1'b0);
        Rdy_Low = 1'b1; DI_Low = line;
        tick;
        Rdy_Low = 1'b0; DI_Low = '0;
        chk("fill_rdy", Rdy_CPU, 1'b0);
        chk("fill_noreq", Req_Low, 1'b0);
        tick;
        chk("post_fill_rdy", Rdy_CPU, 1'b1);
        chk("post_fill_data", DO_CPU, word_of(line, addr));
        exp_hit++;
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] line_a, line_a_mod, line_b, line_c;
        rst = 1'b1; Req_CPU = 1'b0; Wr_CPU = 1'b0; A_CPU = '0; DI_CPU = '0;
        DI_Low = '0; Rdy_Low = 1'b0;
        tick;
        tick;
        chk("rst_rdy_cpu", Rdy_CPU, 1'b0);
        chk("rst_req_low", Req_Low, 1'b0);
        chk("rst_wr_low", Wr_Low, 1'b0);
        chk_stats("rst");
        rst = 1'b0;

        line_a = mkline(32'hAAAA_0000);
        line_b = mkline(32'hBBBB_0000);
        line_c = mkline(32'hCCCC_0000);
        line_a_mod = line_a;
        line_a_mod[63:32] = 32'h1234_5678;

        // Set 4: cold miss, store/load hits, second way, dirty eviction.
        load_miss(32'h0000_0040, 1'b0, '0, '0, line_a);
        store_hit(32'h0000_0044, 32'h1234_5678);
        load_hit(32'h0000_0044, 32'h1234_5678);
        load_miss(32'h0000_0240, 1'b0, '0, '0, line_b);
        load_miss(32'h0000_0440, 1'b1, 28'h000_0004, line_a_mod, line_c);
        load_hit(32'h0000_0240, 32'hBBBB_0000);

        // Set 8: clean evictions walk the round-robin pointer 0 -> 1 -> 0.
        load_miss(32'h0000_0080, 1'b0, '0, '0, mkline(32'hD000_0000));
        load_miss(32'h0000_0280, 1'b0, '0, '0, mkline(32'hD100_0000));
        load_miss(32'h0000_0480, 1'b0, '0, '0, mkline(32'hD200_0000));
        load_miss(32'h0000_0680, 1'b0, '0, '0, mkline(32'hD300_0000));
        load_hit(32'h0000_0480, 32'hD200_0000);
        load_miss(32'h0000_0280, 1'b0, '0, '0, mkline(32'hD400_0000));
        load_hit(32'h0000_0680, 32'hD300_0000);
        load_hit(32'h0000_0688, 32'hD300_0002);
        chk_stats("pre_reset");

        // Reset while fetching abandons the transfer and the contents.
        Req_CPU = 1'b1; Wr_CPU = 1'b0; A_CPU = 32'h0000_0040;
        #1;
        chk("abort_miss_rdy", Rdy_CPU, 1'b0);
        tick;
        chk("abort_fetch_req", Req_Low, 1'b1);
        rst = 1'b1; Req_CPU = 1'b0;
        tick;
        exp_hit = 0; exp_miss = 0; exp_wb = 0;
        chk("abort_req_low", Req_Low, 1'b0);
        chk("abort_rdy_cpu", Rdy_CPU, 1'b0);
        rst = 1'b0;
        Rdy_Low = 1'b1;
        tick;
        Rdy_Low = 1'b0;
        chk("stray_rdy_low_req", Req_Low, 1'b0);
        chk("stray_rdy_low_cpu", Rdy_CPU, 1'b0);
        load_miss(32'h0000_0040, 1'b0, '0, '0, mkline(32'hEEEE_0000));
        chk_stats("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
